// File: rtl/usb_bus_master.sv
// Bus-functional initiator for the 8-bit asynchronous host bus: turns a command plus
// byte stream into timed single or burst register reads and writes on addr/data/cen/rdn/wrn.
module usb_bus_master #(
    parameter int pADDR_WIDTH   = 21,
    parameter int LEN_WIDTH     = 7,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                   usb_clk,
    input  logic                   usb_rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [pADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]   cmd_len,
    input  logic [7:0]             wdata,
    input  logic                   wdata_valid,
    output logic                   wdata_ready,
    output logic [7:0]             rdata,
    output logic                   rdata_valid,
    output logic                   done,
    output logic                   busy,
    output logic [pADDR_WIDTH-1:0] usb_addr,
    output logic                   usb_cen,
    output logic                   usb_rdn,
    output logic                   usb_wrn,
    output logic [7:0]             usb_dout,
    output logic                   usb_dout_en,
    input  logic [7:0]             usb_din
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

    state_t                 state_q;
    logic [3:0]             timer_q;
    logic [LEN_WIDTH-1:0]   count_q;
    logic                   isWrite_q;
    logic                   haveData_q;
    logic [pADDR_WIDTH-1:0] addr_q;
    logic [pADDR_WIDTH-1:0] addr_d;
    logic                   cen_q;
    logic                   rdn_q;
    logic                   wrn_q;
    logic [7:0]             dout_q;
    logic                   doutEn_q;
    logic [7:0]             rdata_q;
    logic                   rdataValid_q;
    logic                   done_q;
    logic                   busy_q;
    logic                   lastHold;
    logic                   takeByte;

    assign addr_d   = addr_q + pADDR_WIDTH'(1);
    assign lastHold = (state_q == HOLD) && (timer_q == '0);

    // A write byte is taken on the edge that enters SETUP, or later while SETUP stalls for it.
    assign takeByte = wdata_valid &&
                      (((state_q == IDLE) && cmd_valid && cmd_write) ||
                       ((state_q == SETUP) && isWrite_q && !haveData_q) ||
                       (lastHold && (count_q != '0) && isWrite_q));

    always_ff @(posedge usb_clk or negedge usb_rst_n) begin
        if (!usb_rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            count_q      <= '0;
            isWrite_q    <= 1'b0;
            haveData_q   <= 1'b0;
            addr_q       <= '0;
            cen_q        <= 1'b1;
            rdn_q        <= 1'b1;
            wrn_q        <= 1'b1;
            dout_q       <= '0;
            doutEn_q     <= 1'b0;
            rdata_q      <= '0;
            rdataValid_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            rdataValid_q <= 1'b0;
            if (takeByte) begin
                dout_q     <= wdata;
                doutEn_q   <= 1'b1;
                haveData_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        state_q   <= SETUP;
                        timer_q   <= SETUP_LOAD;
                        isWrite_q <= cmd_write;
                        count_q   <= cmd_len;
                        addr_q    <= cmd_addr;
                        busy_q    <= 1'b1;
                        cen_q     <= 1'b0;
                        if (!takeByte) begin
                            haveData_q <= !cmd_write;
                            doutEn_q   <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    if (haveData_q) begin
                        if (timer_q == '0) begin
                            state_q <= STROBE;
                            timer_q <= STROBE_LOAD;
                            if (isWrite_q) begin
                                wrn_q <= 1'b0;
                            end else begin
                                rdn_q <= 1'b0;
                            end
                        end else begin
                            timer_q <= timer_q - 4'd1;
                        end
                    end
                end
                STROBE: begin
                    if (timer_q == '0) begin
                        state_q <= HOLD;
                        timer_q <= HOLD_LOAD;
                        rdn_q   <= 1'b1;
                        wrn_q   <= 1'b1;
                        if (!isWrite_q) begin
                            rdata_q      <= usb_din;
                            rdataValid_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q - 4'd1;
                    end
                end
                HOLD: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - 4'd1;
                    end else if (count_q == '0) begin
                        state_q    <= IDLE;
                        cen_q      <= 1'b1;
                        doutEn_q   <= 1'b0;
                        haveData_q <= 1'b0;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        state_q <= SETUP;
                        timer_q <= SETUP_LOAD;
                        count_q <= count_q - LEN_WIDTH'(1);
                        addr_q  <= addr_d;
                        if (!takeByte) begin
                            haveData_q <= !isWrite_q;
                            doutEn_q   <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign wdata_ready = takeByte;
    assign rdata       = rdata_q;
    assign rdata_valid = rdataValid_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign usb_addr    = addr_q;
    assign usb_cen     = cen_q;
    assign usb_rdn     = rdn_q;
    assign usb_wrn     = wrn_q;
    assign usb_dout    = dout_q;
    assign usb_dout_en = doutEn_q;

endmodule
